muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS HI/LO multiply/divide unit, 32 radix-2 steps on one shared adder.
// Define MULDIV_DIV_EN to build DIV/DIVU support; without it divides are ignored like unknown ops.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [31:0] instruction,
    input  logic [31:0] regA,
    input  logic [31:0] regB,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MULDIV_DIV_EN
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, MUL, FIX, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] acc_q, acc_d, quo_q, quo_d, mcand_q, mcand_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;

    logic        special;
    logic [5:0]  funct;
    logic        op_mult, op_multu, op_mul, op_mfhi, op_mthi, op_mflo, op_mtlo;
    logic        hilo_op, signed_op, a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [31:0] mul_acc, mul_quo;
    logic [63:0] prod, prod_fix;
    logic        unused_bits;

    assign special     = (instruction[31:26] == 6'd0);
    assign funct       = instruction[5:0];
    assign unused_bits = ^instruction[25:6];
    assign op_mult     = special && (funct == 6'h18);
    assign op_multu    = special && (funct == 6'h19);
    assign op_mfhi     = special && (funct == 6'h10);
    assign op_mthi     = special && (funct == 6'h11);
    assign op_mflo     = special && (funct == 6'h12);
    assign op_mtlo     = special && (funct == 6'h13);
    assign op_mul      = op_mult || op_multu;

`ifdef MULDIV_DIV_EN
    logic        op_div, op_divu, op_dv;
    logic        rneg_q, rneg_d, div_q, div_d;
    logic [32:0] add_a, add_b;
    logic        add_c;
    logic [33:0] sum;
    logic        ge;
    logic [31:0] div_acc, div_quo, rem_fix, quo_fix;

    assign op_div    = special && (funct == 6'h1A);
    assign op_divu   = special && (funct == 6'h1B);
    assign op_dv     = op_div || op_divu;
    assign hilo_op   = op_mul || op_dv || op_mfhi || op_mthi || op_mflo || op_mtlo;
    assign signed_op = op_mult || op_div;

    // Shared adder: add for multiply steps, trial subtract (a - d via ~d + 1) for divide steps
    always_comb begin
        add_a = {1'b0, acc_q};
        add_b = {1'b0, mcand_q & {32{quo_q[0]}}};
        add_c = 1'b0;
        if (state_q == DIV) begin
            add_a = {acc_q, quo_q[31]};
            add_b = ~{1'b0, mcand_q};
            add_c = 1'b1;
        end
    end
    assign sum     = {1'b0, add_a} + {1'b0, add_b} + {33'd0, add_c};
    assign ge      = sum[33];
    assign div_acc = ge ? sum[31:0] : add_a[31:0];
    assign div_quo = {quo_q[30:0], ge};
    assign rem_fix = rneg_q ? (~acc_q + 32'd1) : acc_q;
    assign quo_fix = neg_q  ? (~quo_q + 32'd1) : quo_q;
`else
    logic [32:0] sum;

    assign hilo_op   = op_mul || op_mfhi || op_mthi || op_mflo || op_mtlo;
    assign signed_op = op_mult;
    assign sum       = {1'b0, acc_q} + {1'b0, mcand_q & {32{quo_q[0]}}};
`endif

    assign a_neg    = signed_op && regA[31];
    assign b_neg    = signed_op && regB[31];
    assign abs_a    = a_neg ? (~regA + 32'd1) : regA;
    assign abs_b    = b_neg ? (~regB + 32'd1) : regB;
    assign mul_acc  = sum[32:1];
    assign mul_quo  = {sum[0], quo_q[31:1]};
    assign prod     = {acc_q, quo_q};
    assign prod_fix = neg_q ? (~prod + 64'd1) : prod;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
`ifdef MULDIV_DIV_EN
        rneg_d  = rneg_q;
        div_d   = div_q;
`endif
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid && !flush) begin
                    if (op_mthi) hi_d = regA;
                    if (op_mtlo) lo_d = regA;
                    if (op_mul) begin
                        state_d = MUL;
                        acc_d   = '0;
                        quo_d   = abs_b;
                        mcand_d = abs_a;
                        cnt_d   = '0;
                        neg_d   = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                        div_d   = 1'b0;
`endif
                    end
`ifdef MULDIV_DIV_EN
                    // Divide by zero keeps the all-ones quotient unsigned; remainder sign still follows regA
                    if (op_dv) begin
                        state_d = DIV;
                        acc_d   = '0;
                        quo_d   = abs_a;
                        mcand_d = abs_b;
                        cnt_d   = '0;
                        neg_d   = (a_neg ^ b_neg) && (regB != '0);
                        rneg_d  = a_neg;
                        div_d   = 1'b1;
                    end
`endif
                end
            end
            MUL: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = mul_acc;
                    quo_d = mul_quo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = FIX;
                end
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = div_acc;
                    quo_d = div_quo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = FIX;
                end
            end
`endif
            FIX: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
`ifdef MULDIV_DIV_EN
                    if (div_q) {hi_d, lo_d} = {rem_fix, quo_fix};
                    else       {hi_d, lo_d} = prod_fix;
`else
                    {hi_d, lo_d} = prod_fix;
`endif
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
`ifdef MULDIV_DIV_EN
            rneg_q  <= rneg_d;
            div_q   <= div_d;
`endif
        end
    end

    assign stall  = valid && hilo_op && (state_q != IDLE);
    assign result = op_mfhi ? hi_q : (op_mflo ? lo_q : '0);
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule
